// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field positions, ExcCodes and
// sequencer state encoding.
package cp0_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Field bit positions
  localparam int IE    = 0;
  localparam int EXL   = 1;
  localparam int IM_LO = 8;
  localparam int IP_LO = 10;
  localparam int BD    = 31;

  localparam logic [31:0] EXL_MASK = 32'h0000_0002;

  // ExcCode values
  localparam logic [4:0] INT  = 5'd0;
  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;
  localparam logic [4:0] SYS  = 5'd8;
  localparam logic [4:0] BP   = 5'd9;
  localparam logic [4:0] RI   = 5'd10;
  localparam logic [4:0] OV   = 5'd12;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_W_EPC    = 3'd1;
  localparam state_t S_W_CAUSE  = 3'd2;
  localparam state_t S_W_STATUS = 3'd3;
  localparam state_t S_E_STATUS = 3'd4;
  localparam state_t S_REDIRECT = 3'd5;

endpackage

// File: rtl/cp0_irq_pending.sv
// Masks the hardware interrupt lines with Status.IM/IE/EXL.
module cp0_irq_pending #(
  parameter int NUM_IRQ = 6
) (
  input  logic [NUM_IRQ-1:0] int_req,
  input  logic [NUM_IRQ-1:0] im,
  input  logic               ie,
  input  logic               exl,
  output logic               irq_pend,
  output logic [NUM_IRQ-1:0] ip
);

  logic [NUM_IRQ-1:0] masked;

  // Pending only while interrupts are enabled and not already in an exception
  always_comb begin
    masked   = int_req & im;
    irq_pend = (|masked) & ie & ~exl;
    // Cause.IP reports the raw request lines, not the masked ones
    ip       = int_req;
  end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Exception/interrupt/ERET sequencer driving the CP0 register file ports.
module cp0_exception_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic               exc_bd,
  input  logic               eret_valid,
  input  logic [NUM_IRQ-1:0] int_req,
  output logic               cp0_we,
  output logic [4:0]         cp0_waddr,
  output logic [31:0]        cp0_wdata,
  output logic [4:0]         cp0_raddr,
  input  logic [31:0]        cp0_rdata,
  output logic               stall,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  state_t             state, state_d;
  logic [4:0]         code_q, code_d;
  logic [31:0]        pc_q, pc_d;
  logic               bd_q, bd_d;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic               eret_q, eret_d;
  logic [31:0]        next_pc_q, next_pc_d;

  logic               irq_pend;
  logic [NUM_IRQ-1:0] irq_ip;
  logic [31:0]        cause_word;

  // In IDLE cp0_raddr is Status, so cp0_rdata carries the live Status value
  cp0_irq_pending #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_pending (
    .int_req  (int_req),
    .im       (cp0_rdata[IM_LO +: NUM_IRQ]),
    .ie       (cp0_rdata[IE]),
    .exl      (cp0_rdata[EXL]),
    .irq_pend (irq_pend),
    .ip       (irq_ip)
  );

  // Assemble the Cause word from the latched event
  always_comb begin
    cause_word                     = '0;
    cause_word[BD]                 = bd_q;
    cause_word[IP_LO +: NUM_IRQ]   = ip_q;
    cause_word[6:2]                = code_q;
  end

  // Next-state, latch updates and CP0/fetch outputs
  always_comb begin
    state_d        = state;
    code_d         = code_q;
    pc_d           = pc_q;
    bd_d           = bd_q;
    ip_d           = ip_q;
    eret_d         = eret_q;
    next_pc_d      = next_pc_q;
    cp0_we         = 1'b0;
    cp0_waddr      = 5'd0;
    cp0_wdata      = 32'd0;
    cp0_raddr      = CP0_STATUS;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    case (state)
      S_IDLE: begin
        stall = 1'b0;
        // Priority: exception > interrupt > ERET
        if (exc_valid) begin
          code_d  = exc_code;
          pc_d    = exc_pc;
          bd_d    = exc_bd;
          ip_d    = '0;
          eret_d  = 1'b0;
          stall   = 1'b1;
          state_d = S_W_EPC;
        end else if (irq_pend) begin
          code_d  = INT;
          pc_d    = exc_pc;
          bd_d    = exc_bd;
          ip_d    = irq_ip;
          eret_d  = 1'b0;
          stall   = 1'b1;
          state_d = S_W_EPC;
        end else if (eret_valid) begin
          eret_d  = 1'b1;
          stall   = 1'b1;
          state_d = S_E_STATUS;
        end
      end
      S_W_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_EPC;
        // A delay-slot fault restarts at the preceding branch
        cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d   = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_CAUSE;
        cp0_wdata = cause_word;
        state_d   = S_W_STATUS;
      end
      S_W_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = cp0_rdata | EXL_MASK;
        next_pc_d = EXC_VECTOR;
        state_d   = S_REDIRECT;
      end
      S_E_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = cp0_rdata & ~EXL_MASK;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (eret_q) begin
          cp0_raddr   = CP0_EPC;
          redirect_pc = cp0_rdata;
        end else begin
          redirect_pc = next_pc_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        stall   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // State and event latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      code_q    <= 5'd0;
      pc_q      <= 32'd0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      eret_q    <= 1'b0;
      next_pc_q <= 32'd0;
    end else begin
      state     <= state_d;
      code_q    <= code_d;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      eret_q    <= eret_d;
      next_pc_q <= next_pc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl with a small CP0 register file.
module tb_cp0_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret_valid;
  logic [5:0]  int_req;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_exception_ctrl #(
    .EXC_VECTOR (32'h0000_0180),
    .NUM_IRQ    (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .exc_bd         (exc_bd),
    .eret_valid     (eret_valid),
    .int_req        (int_req),
    .cp0_we         (cp0_we),
    .cp0_waddr      (cp0_waddr),
    .cp0_wdata      (cp0_wdata),
    .cp0_raddr      (cp0_raddr),
    .cp0_rdata      (cp0_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // CP0 register file: combinational read, DUT write port plus a bench preload port
  logic [31:0] regs [32];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_addr = 5'd0;
  logic [31:0] tb_data = 32'd0;

  assign cp0_rdata = regs[cp0_raddr];

  always @(posedge clk) begin
    if (cp0_we) regs[cp0_waddr] <= cp0_wdata;
    else if (tb_we) regs[tb_addr] <= tb_data;
  end

  typedef struct {
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic [5:0]  irq;
    int          lat;
    logic [31:0] rpc;
    logic [31:0] xepc;
    logic [31:0] xcause;
    logic [31:0] xstatus;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = addr;
    tb_data = data;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  // Reference: decide the event from the architectural rules and compute the
  // final CP0 contents and redirect target.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    logic pend = 1'b0;
    for (int i = 0; i < 6; i++)
      if (v.irq[i] && v.status[8 + i]) pend = 1'b1;
    pend = pend && v.status[0] && !v.status[1];
    r.xepc = v.epc; r.xcause = v.cause; r.xstatus = v.status;
    r.lat = 0; r.rpc = 32'd0;
    if (v.exc || pend) begin
      r.lat     = 4;
      r.rpc     = 32'h180;
      r.xepc    = v.bd ? v.pc - 32'd4 : v.pc;
      r.xcause  = (v.bd ? 32'h8000_0000 : 32'd0)
                + (v.exc ? ({27'd0, v.code} * 4) : ({26'd0, v.irq} * 1024));
      r.xstatus = v.status | 32'd2;
    end else if (v.eret) begin
      r.lat     = 2;
      r.rpc     = v.epc;
      r.xstatus = v.status & ~32'd2;
    end
    return r;
  endfunction

  task automatic run_event(input vec_t v, input string name);
    int          got_lat = 0;
    int          nredir = 0;
    logic [31:0] got_rpc = 32'd0;
    logic        stall_ok = 1'b1;
    logic        waddr_ok = 1'b1;
    logic [14:0] wseq = '0;
    int          nw = 0;
    logic [14:0] exp_wseq;
    int          exp_nw;
    preload(5'd12, v.status);
    preload(5'd14, v.epc);
    preload(5'd13, v.cause);
    @(negedge clk);
    exc_valid = v.exc; exc_code = v.code; exc_pc = v.pc; exc_bd = v.bd;
    eret_valid = v.eret; int_req = v.irq;
    #1;
    chk({name, ":accept_stall"}, {31'd0, stall}, {31'd0, v.lat != 0});
    chk({name, ":accept_busy"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    exc_valid = 1'b0; eret_valid = 1'b0; int_req = '0;
    exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cp0_we) begin
        wseq = {wseq[9:0], cp0_waddr};
        nw++;
        if (cp0_waddr == 5'd0) waddr_ok = 1'b0;
      end
      if (redirect_valid) begin
        if (nredir == 0) begin
          got_lat = cyc;
          got_rpc = redirect_pc;
        end
        nredir++;
      end
      if (cyc <= v.lat) begin
        if (!stall || !busy) stall_ok = 1'b0;
      end else if (stall || busy) begin
        stall_ok = 1'b0;
      end
    end
    if (v.lat == 4) begin
      exp_wseq = {5'd14, 5'd13, 5'd12}; exp_nw = 3;
    end else if (v.lat == 2) begin
      exp_wseq = {10'd0, 5'd12}; exp_nw = 1;
    end else begin
      exp_wseq = '0; exp_nw = 0;
    end
    chk({name, ":latency"}, got_lat, v.lat);
    chk({name, ":redirect_cnt"}, nredir, (v.lat != 0) ? 1 : 0);
    if (v.lat != 0) chk({name, ":redirect_pc"}, got_rpc, v.rpc);
    chk({name, ":stall_busy"}, {31'd0, stall_ok}, 32'd1);
    chk({name, ":write_seq"}, {15'd0, wseq, 2'd0} + nw, {15'd0, exp_wseq, 2'd0} + exp_nw);
    chk({name, ":waddr_nonzero"}, {31'd0, waddr_ok}, 32'd1);
    chk({name, ":epc"}, regs[14], v.xepc);
    chk({name, ":cause"}, regs[13], v.xcause);
    chk({name, ":status"}, regs[12], v.xstatus);
  endtask

  vec_t tbl[7];

  initial begin
    rst = 1'b1;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
    eret_valid = 1'b0; int_req = '0;

    tbl[0] = '{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd12, 32'h00400010, 1'b0, 1'b0, 6'h00,
               4, 32'h180, 32'h00400010, 32'h00000030, 32'h0000FF03};
    tbl[1] = '{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd12, 32'h00400014, 1'b1, 1'b0, 6'h00,
               4, 32'h180, 32'h00400010, 32'h80000030, 32'h0000FF03};
    tbl[2] = '{32'h00000101, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00400100, 1'b0, 1'b0, 6'h01,
               4, 32'h180, 32'h00400100, 32'h00000400, 32'h00000103};
    tbl[3] = '{32'h00000103, 32'h11110000, 32'h0, 1'b0, 5'd0, 32'h00400100, 1'b0, 1'b0, 6'h01,
               0, 32'h0, 32'h11110000, 32'h00000000, 32'h00000103};
    tbl[4] = '{32'h0000FF03, 32'h00400020, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 6'h00,
               2, 32'h00400020, 32'h00400020, 32'h00000000, 32'h0000FF01};
    tbl[5] = '{32'h0000FF03, 32'h00400020, 32'h0, 1'b1, 5'd4, 32'h00400040, 1'b0, 1'b1, 6'h00,
               4, 32'h180, 32'h00400040, 32'h00000010, 32'h0000FF03};
    tbl[6] = '{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd8, 32'h00400050, 1'b1, 1'b0, 6'h3F,
               4, 32'h180, 32'h0040004C, 32'h80000020, 32'h0000FF03};

    // Reset state
    #12;
    chk("rst:busy", {31'd0, busy}, 32'd0);
    chk("rst:stall", {31'd0, stall}, 32'd0);
    chk("rst:we", {31'd0, cp0_we}, 32'd0);
    chk("rst:waddr", {27'd0, cp0_waddr}, 32'd0);
    chk("rst:raddr", {27'd0, cp0_raddr}, 32'd12);
    chk("rst:redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst:redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_event(tbl[i], $sformatf("vec%0d", i));

    // ERET and interrupt together: interrupt wins
    begin
      vec_t v;
      v = '{32'h0000FF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h00400060, 1'b1, 1'b1, 6'h01,
            4, 32'h180, 32'h0040005C, 32'h80000400, 32'h0000FF03};
      run_event(v, "irq_over_eret");
    end

    // Asynchronous reset in W_CAUSE, then a fresh exception
    preload(5'd12, 32'h0000FF01);
    preload(5'd14, 32'h0);
    preload(5'd13, 32'h0);
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd10; exc_pc = 32'h00400080; exc_bd = 1'b0;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst:in_w_cause", {27'd0, cp0_waddr}, 32'd13);
    rst = 1'b1;
    #1;
    chk("midrst:busy", {31'd0, busy}, 32'd0);
    chk("midrst:stall", {31'd0, stall}, 32'd0);
    chk("midrst:we", {31'd0, cp0_we}, 32'd0);
    chk("midrst:raddr", {27'd0, cp0_raddr}, 32'd12);
    chk("midrst:epc_kept", regs[14], 32'h00400080);
    chk("midrst:cause_unwritten", regs[13], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v = '{32'h0000FF01, 32'h0, 32'h0, 1'b1, 5'd10, 32'h00400090, 1'b0, 1'b0, 6'h00,
            0, 32'h0, 32'h0, 32'h0, 32'h0};
      run_event(predict(v), "after_rst");
    end

    // Randomised events against the reference
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.status = $urandom;
      v.epc    = $urandom;
      v.cause  = $urandom;
      v.exc    = ($urandom_range(0, 2) == 0);
      v.code   = 5'($urandom_range(0, 31));
      v.pc     = $urandom;
      v.bd     = 1'($urandom_range(0, 1));
      v.eret   = 1'($urandom_range(0, 1));
      v.irq    = 6'($urandom_range(0, 63));
      run_event(predict(v), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
- Sequencer that drives the CP0 register file's write port and read address.
- Accepts synchronous exceptions, external interrupts and ERET from the pipeline.
- For an exception or interrupt: saves EPC, Cause and Status into CP0, then redirects fetch to the exception vector.
- For ERET: clears Status.EXL, then redirects fetch to EPC.
- Sits between the pipeline control unit and the CP0 register file, and stalls the pipeline while sequencing.

Parameters:
- EXC_VECTOR, 32'h0000_0180, fetch target for every exception and interrupt.
- NUM_IRQ, 6, number of hardware interrupt lines (1..6).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- exc_valid  in  1  synchronous exception presented by the pipeline (level).
- exc_code  in  5  ExcCode of the presented exception.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction sits in a branch delay slot.
- eret_valid  in  1  ERET presented by the pipeline (level).
- int_req  in  NUM_IRQ  hardware interrupt request lines (level).
- cp0_we  out  1  CP0 write enable.
- cp0_waddr  out  5  CP0 write address.
- cp0_wdata  out  32  CP0 write data.
- cp0_raddr  out  5  CP0 read address.
- cp0_rdata  in  32  CP0 read data; combinational from cp0_raddr, same cycle.
- stall  out  1  pipeline hold.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  redirect target.
- busy  out  1  state is not IDLE.

Behaviour:

CP0 register map and fields:
- Registers: Status=12, Cause=13, EPC=14.
- Status: IE=bit0, EXL=bit1, IM=bits[15:8].
- Cause: BD=bit31, IP=bits[10+NUM_IRQ-1:10], ExcCode=bits[6:2].

States: IDLE, W_EPC, W_CAUSE, W_STATUS, E_STATUS, REDIRECT.

Reset:
- State is IDLE; internal latches are cleared.
- All outputs are 0, except cp0_raddr=12 (IDLE default).

IDLE:
- cp0_raddr=12 and cp0_we=0.
- Interrupt pending (irq_pend) = |(int_req & Status.IM[NUM_IRQ-1:0]) & Status.IE & ~Status.EXL.
- Accept priority is exc_valid > irq_pend > eret_valid; exactly one event is accepted per IDLE cycle.
- Accepting exc_valid latches code, pc and bd, then goes to W_EPC.
- Accepting an interrupt latches code=0, pc=exc_pc, bd=exc_bd and IP=int_req, then goes to W_EPC.
- Accepting ERET goes to E_STATUS.
- stall=1 combinationally in the accept cycle.

W_EPC:
- we=1, waddr=14.
- wdata = bd ? pc-32'd4 : pc (modulo 2^32).

W_CAUSE:
- we=1, waddr=13.
- wdata = {bd, 0..., IP, 0..., code, 2'b00}; IP is 0 for synchronous exceptions.

W_STATUS:
- raddr=12, we=1, waddr=12, wdata = cp0_rdata | 32'h2.
- next_pc is set to EXC_VECTOR.

E_STATUS:
- raddr=12, we=1, waddr=12, wdata = cp0_rdata & ~32'h2.

REDIRECT:
- redirect_valid=1 for exactly this cycle, then return to IDLE.
- redirect_pc: for an exception path, the latched EXC_VECTOR; for an ERET path, cp0_raddr=14 and redirect_pc=cp0_rdata.

Latency:
- Exception or interrupt: accept at cycle 0; writes at cycles 1, 2, 3; redirect at cycle 4.
- ERET: accept at cycle 0; Status write at cycle 1; redirect at cycle 2.

Stall and busy:
- stall=1 in every non-IDLE state, including REDIRECT.
- busy=1 in every non-IDLE state.

Boundary conditions:
- Events arriving in non-IDLE states are ignored. Upstream deasserts after the redirect flush.
- exc_valid and eret_valid asserted in the same cycle: the exception wins and ERET is dropped.
- An interrupt is masked while EXL=1, so nested entry cannot occur.
- exc_valid with EXL=1 is still taken; EPC is overwritten.
- Reset mid-sequence returns to IDLE immediately. Partially written CP0 registers are not rolled back.
- cp0_waddr is never 0.

Decomposition:
- Shared package cp0_pkg holds:
  - register indices CP0_STATUS, CP0_CAUSE, CP0_EPC;
  - bit positions IE, EXL, IM_LO, IP_LO, BD;
  - ExcCode constants INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12;
  - the state enum.
- One sub-module, cp0_irq_pending: combinational masking of int_req by IM, IE and EXL, producing irq_pend and the IP vector.

Test Plan:
1. Status=32'h0000_FF01, exc_valid, code=12, pc=32'h0040_0010, bd=0 -> EPC=0x00400010, Cause=0x00000030, Status=0x0000FF03; redirect_pc=0x180 at cycle 4; stall high for cycles 0–4.
2. Same as 1 with bd=1, pc=32'h0040_0014 -> EPC=0x00400010, Cause bit31=1.
3. Status=0x0000_0101, int_req=6'b000001, no exc -> Cause=0x00000400, ExcCode=0, redirect_pc=0x180; repeat with Status=0x0000_0103 -> no action, busy stays 0.
4. Status=0x0000_FF03, EPC=0x0040_0020, eret_valid -> Status=0x0000FF01 at cycle 1; redirect_valid and redirect_pc=0x00400020 at cycle 2; redirect_valid high for exactly 1 cycle.
5. exc_valid and eret_valid together in IDLE -> exception path taken (3 writes); ERET ignored.
6. Assert rst during W_CAUSE -> outputs 0 and state IDLE immediately (asynchronous); next exc_valid restarts from W_EPC.
